// File: rtl/word_serializer_pkg.sv
// ser_pkg: shared FSM encoding and default word width for the word serializer
package ser_pkg;
  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;
  localparam int SER_WORD_W = 16;
endpackage

// File: rtl/word_serializer_if.sv
// word_serializer_if: word-side valid/ready input, bit-side valid/ready output with last marker, busy flag
interface word_serializer_if
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WORD_W
);
  logic [WIDTH-1:0] __word_i;
  logic __word_valid_i, __word_ready_o;
  logic __bit_o, __bit_valid_o, __bit_ready_i, __bit_last_o, __busy_o;
  modport master (
    output __word_i, __word_valid_i, __bit_ready_i,
    input  __word_ready_o, __bit_o, __bit_valid_o, __bit_last_o, __busy_o
  );
  modport slave (
    input  __word_i, __word_valid_i, __bit_ready_i,
    output __word_ready_o, __bit_o, __bit_valid_o, __bit_last_o, __busy_o
  );
endinterface

// File: rtl/word_serializer_bit_counter.sv
// ser_bit_counter: modulo-WIDTH beat counter (clk, async low reset rst_n, inc, clr) flagging the final position via at_max
module ser_bit_counter #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  assign at_max = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= at_max ? '0 : cnt + CW'(1);
endmodule

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial stage (__clk, async low __arst_n, bus = word in / serial bit out handshake)
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_WORD_W,
  parameter int LSB_FIRST = 0
) (
  input  logic                 __clk,
  input  logic                 __arst_n,
  word_serializer_if.slave     bus
);
  ser_state_e state;
  logic [WIDTH-1:0] sreg;
  logic beat, last_beat, acc, at_max;
  assign beat = bus.__bit_valid_o & bus.__bit_ready_i;
  assign last_beat = beat & at_max;
  assign acc = bus.__word_valid_i & bus.__word_ready_o;
  assign bus.__word_ready_o = (state == SER_IDLE) | last_beat;
  assign bus.__bit_valid_o = state == SER_SHIFT;
  assign bus.__busy_o = state == SER_SHIFT;
  assign bus.__bit_o = bus.__bit_valid_o & (LSB_FIRST != 0 ? sreg[0] : sreg[WIDTH-1]);
  assign bus.__bit_last_o = bus.__bit_valid_o & at_max;
  // Held at zero while idle, so every frame starts counting from bit 0.
  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (__clk),
    .rst_n  (__arst_n),
    .inc    (beat),
    .clr    (state == SER_IDLE),
    .at_max (at_max)
  );
  // acc while shifting only happens on last_beat, which makes the reload path back-to-back.
  always_ff @(posedge __clk or negedge __arst_n)
    if (!__arst_n) begin
      state <= SER_IDLE;
      sreg  <= '0;
    end else if (acc) begin
      state <= SER_SHIFT;
      sreg  <= bus.__word_i;
    end else if (last_beat) state <= SER_IDLE;
    else if (beat) sreg <= LSB_FIRST != 0 ? sreg >> 1 : sreg << 1;
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: MSB- and LSB-first serializers driven in lockstep, checked against a word/index reference model
module tb_word_serializer;
  import ser_pkg::*;
  localparam int W = SER_WORD_W;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;
  word_serializer_if #(.WIDTH(W)) bm ();
  word_serializer_if #(.WIDTH(W)) bl ();
  word_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_m (.__clk(clk), .__arst_n(arst_n), .bus(bm.slave));
  word_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_l (.__clk(clk), .__arst_n(arst_n), .bus(bl.slave));
  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] m_word [2];
  int m_idx [2];
  bit m_act [2];
  logic [W-1:0] rx [2];
  int n_beat [2];
  int n_last [2];
  int n_acc_busy [2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mon(input int k, input logic wv, input logic wr, input logic bo, input logic bv,
                     input logic br, input logic bla, input logic busy, input logic [W-1:0] w);
    bit fin, acc;
    fin = m_act[k] && br && m_idx[k] == W - 1;
    acc = wv && (!m_act[k] || fin);
    chk($sformatf("valid%0d", k), bv, m_act[k]);
    chk($sformatf("busy%0d", k), busy, m_act[k]);
    chk($sformatf("ready%0d", k), wr, !m_act[k] || fin);
    if (m_act[k]) begin
      chk($sformatf("bit%0d_idx%0d", k, m_idx[k]), bo, k == 1 ? m_word[k][m_idx[k]] : m_word[k][W-1-m_idx[k]]);
      chk($sformatf("last%0d_idx%0d", k, m_idx[k]), bla, m_idx[k] == W - 1);
    end
    if (bv && br) begin
      rx[k] = {rx[k][W-2:0], bo};
      n_beat[k]++;
      n_last[k] += int'(bla);
    end
    if (wv && wr && bv) n_acc_busy[k]++;
    if (m_act[k] && br) begin
      m_idx[k]++;
      if (fin) begin
        m_act[k] = 1'b0;
        m_idx[k] = 0;
      end
    end
    if (acc) begin
      m_word[k] = w;
      m_idx[k] = 0;
      m_act[k] = 1'b1;
    end
  endtask
  always @(negedge clk)
    if (!arst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 1'b0;
        m_idx[k] = 0;
      end
    end else begin
      mon(0, bm.__word_valid_i, bm.__word_ready_o, bm.__bit_o, bm.__bit_valid_o, bm.__bit_ready_i,
          bm.__bit_last_o, bm.__busy_o, bm.__word_i);
      mon(1, bl.__word_valid_i, bl.__word_ready_o, bl.__bit_o, bl.__bit_valid_o, bl.__bit_ready_i,
          bl.__bit_last_o, bl.__busy_o, bl.__word_i);
    end
  task automatic set_word(input logic wv, input logic [W-1:0] w);
    bm.__word_valid_i = wv;
    bl.__word_valid_i = wv;
    bm.__word_i = w;
    bl.__word_i = w;
  endtask
  task automatic set_br(input logic br);
    bm.__bit_ready_i = br;
    bl.__bit_ready_i = br;
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr_cnt();
    for (int k = 0; k < 2; k++) begin
      rx[k] = '0;
      n_beat[k] = 0;
      n_last[k] = 0;
      n_acc_busy[k] = 0;
    end
  endtask
  task automatic send(input logic [W-1:0] w, input bit rnd);
    int t;
    t = 0;
    set_word(1'b1, w);
    while (!bm.__word_ready_o && t < 400) begin
      if (rnd) set_br($urandom_range(0, 3) != 0);
      wait_cyc(1);
      t++;
    end
    if (t >= 400) chk("send_timeout", 0, 1);
    wait_cyc(1);
    set_word(1'b0, W'($urandom));
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_ready_m"}, bm.__word_ready_o, 1);
    chk({tag, "_valid_m"}, bm.__bit_valid_o, 0);
    chk({tag, "_bit_m"}, bm.__bit_o, 0);
    chk({tag, "_last_m"}, bm.__bit_last_o, 0);
    chk({tag, "_busy_m"}, bm.__busy_o, 0);
    chk({tag, "_ready_l"}, bl.__word_ready_o, 1);
    chk({tag, "_valid_l"}, bl.__bit_valid_o, 0);
    chk({tag, "_bit_l"}, bl.__bit_o, 0);
    chk({tag, "_last_l"}, bl.__bit_last_o, 0);
    chk({tag, "_busy_l"}, bl.__busy_o, 0);
  endtask
  task automatic frame_chk(input string tag, input logic [W-1:0] exp_m, input logic [W-1:0] exp_l,
                           input int beats, input int lasts);
    chk({tag, "_rx_m"}, rx[0], exp_m);
    chk({tag, "_rx_l"}, rx[1], exp_l);
    chk({tag, "_beats_m"}, n_beat[0], beats);
    chk({tag, "_beats_l"}, n_beat[1], beats);
    chk({tag, "_lasts_m"}, n_last[0], lasts);
    chk({tag, "_lasts_l"}, n_last[1], lasts);
    chk({tag, "_idle_ready"}, bm.__word_ready_o, 1);
    chk({tag, "_idle_busy"}, bm.__busy_o, 0);
  endtask
  initial begin
    set_word(1'b0, '0);
    set_br(1'b0);
    clr_cnt();
    #12;
    rst_chk("reset");
    #5 arst_n = 1'b1;
    wait_cyc(1);
    clr_cnt();
    set_br(1'b1);
    send(16'hA5C3, 0);
    wait_cyc(17);
    frame_chk("a5c3", 16'hA5C3, 16'hC3A5, 16, 1);
    clr_cnt();
    set_br(1'b0);
    send(16'h8001, 0);
    wait_cyc(3);
    set_br(1'b1);
    wait_cyc(15);
    set_br(1'b0);
    wait_cyc(3);
    chk("bp_mid_beats", n_beat[0], 15);
    chk("bp_mid_last", bm.__bit_last_o, 1);
    chk("bp_mid_valid", bm.__bit_valid_o, 1);
    set_br(1'b1);
    wait_cyc(3);
    frame_chk("bp8001", 16'h8001, 16'h8001, 16, 1);
    clr_cnt();
    send(16'hFFFF, 0);
    send(16'h0001, 0);
    wait_cyc(17);
    frame_chk("b2b", 16'h0001, 16'h8000, 32, 2);
    chk("b2b_acc_busy", n_acc_busy[0], 1);
    clr_cnt();
    send(16'h0003, 0);
    wait_cyc(17);
    frame_chk("lsb0003", 16'h0003, 16'hC000, 16, 1);
    clr_cnt();
    send(16'hF0F0, 0);
    wait_cyc(5);
    #2 arst_n = 1'b0;
    #1 rst_chk("midrst");
    @(posedge clk);
    #3 arst_n = 1'b1;
    wait_cyc(1);
    chk("midrst_no_beats", n_beat[0], 5);
    clr_cnt();
    send(16'h1234, 0);
    wait_cyc(17);
    frame_chk("post_rst", 16'h1234, 16'h2C48, 16, 1);
    clr_cnt();
    send(16'hBEEF, 0);
    set_word(1'b0, 16'h4110);
    wait_cyc(17);
    frame_chk("chg", 16'hBEEF, 16'hF77D, 16, 1);
    clr_cnt();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        set_br($urandom_range(0, 1) != 0);
        wait_cyc(1);
      end
      send(W'($urandom), 1);
    end
    set_br(1'b1);
    wait_cyc(20);
    chk("rnd_beats_m", n_beat[0], 40 * W);
    chk("rnd_beats_l", n_beat[1], 40 * W);
    chk("rnd_lasts_m", n_last[0], 40);
    chk("rnd_lasts_l", n_last[1], 40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
